// File: rtl/cv32e40p_apu_arb_pkg.sv
// Shared widths and state encoding for the APU arbiter that lets several
// cv32e40p cores share one FPU.
package cv32e40p_apu_arb_pkg;

    localparam int APU_NARGS_CPU    = 3;
    localparam int APU_WOP_CPU      = 6;
    localparam int APU_NDSFLAGS_CPU = 15;
    localparam int APU_NUSFLAGS_CPU = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RSP
    } apu_arb_state_e;

endpackage

// File: rtl/cv32e40p_apu_arbiter_if.sv
// Bundle of the per-core APU ports and the single FPU-side APU port.
// The arbiter uses the slave view; the cores/FPU environment uses the master view.
interface cv32e40p_apu_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import cv32e40p_apu_arb_pkg::*;

    logic [NUM_REQ-1:0]                                req_i;
    logic [NUM_REQ-1:0]                                gnt_o;
    logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0]       operands_i;
    logic [NUM_REQ-1:0][APU_WOP_CPU-1:0]               op_i;
    logic [NUM_REQ-1:0][APU_NDSFLAGS_CPU-1:0]          flags_i;
    logic [NUM_REQ-1:0]                                rvalid_o;
    logic [31:0]                                       rdata_o;
    logic [APU_NUSFLAGS_CPU-1:0]                       rflags_o;

    logic                                              apu_req_o;
    logic                                              apu_gnt_i;
    logic [APU_NARGS_CPU-1:0][31:0]                    apu_operands_o;
    logic [APU_WOP_CPU-1:0]                            apu_op_o;
    logic [APU_NDSFLAGS_CPU-1:0]                       apu_flags_o;
    logic                                              apu_rvalid_i;
    logic [31:0]                                       apu_rdata_i;
    logic [APU_NUSFLAGS_CPU-1:0]                       apu_rflags_i;

    modport slave (
        input  req_i, operands_i, op_i, flags_i,
        input  apu_gnt_i, apu_rvalid_i, apu_rdata_i, apu_rflags_i,
        output gnt_o, rvalid_o, rdata_o, rflags_o,
        output apu_req_o, apu_operands_o, apu_op_o, apu_flags_o
    );

    modport master (
        output req_i, operands_i, op_i, flags_i,
        output apu_gnt_i, apu_rvalid_i, apu_rdata_i, apu_rflags_i,
        input  gnt_o, rvalid_o, rdata_o, rflags_o,
        input  apu_req_o, apu_operands_o, apu_op_o, apu_flags_o
    );

endinterface

// File: rtl/cv32e40p_apu_rr_picker.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping from the highest index back to zero.
module cv32e40p_apu_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    idx_o,
    output logic [NUM_REQ-1:0] onehot_o
);

    logic [ID_W-1:0] cand;

    // Scan from the farthest offset down so the closest match to ptr_i wins last.
    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        cand     = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = ID_W'((int'(ptr_i) + off) % NUM_REQ);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
        if (valid_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Shares one FPU between NUM_REQ cv32e40p cores: round-robin issue, a single
// operation in flight, and the response steered back to the issuing core.
module cv32e40p_apu_arbiter
    import cv32e40p_apu_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    cv32e40p_apu_arbiter_if.slave  bus,
    output logic                   busy_o,
    output logic [ID_W-1:0]        owner_o
);

    apu_arb_state_e     state_q, state_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    sel_idx;
    logic               win_valid;
    logic [ID_W-1:0]    win_idx;
    logic [NUM_REQ-1:0] win_onehot;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + ID_W'(1);
    endfunction

    cv32e40p_apu_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req_i    (bus.req_i),
        .ptr_i    (rr_ptr_q),
        .valid_o  (win_valid),
        .idx_o    (win_idx),
        .onehot_o (win_onehot)
    );

    // Once a request has been offered to the FPU, the selection is locked to the owner
    // until the FPU accepts it; the pointer only advances when a response completes.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        sel_idx       = owner_q;
        bus.gnt_o     = '0;
        bus.rvalid_o  = '0;
        bus.apu_req_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    sel_idx       = win_idx;
                    owner_d       = win_idx;
                    bus.apu_req_o = 1'b1;
                    if (bus.apu_gnt_i) begin
                        bus.gnt_o = win_onehot;
                        if (bus.apu_rvalid_i) begin
                            bus.rvalid_o = win_onehot;
                            rr_ptr_d     = wrap_inc(win_idx);
                        end else begin
                            state_d = WAIT_RSP;
                        end
                    end else begin
                        state_d = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                if (bus.req_i[owner_q]) begin
                    bus.apu_req_o = 1'b1;
                    if (bus.apu_gnt_i) begin
                        bus.gnt_o[owner_q] = 1'b1;
                        if (bus.apu_rvalid_i) begin
                            bus.rvalid_o[owner_q] = 1'b1;
                            rr_ptr_d              = wrap_inc(owner_q);
                            state_d               = IDLE;
                        end else begin
                            state_d = WAIT_RSP;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_RSP: begin
                if (bus.apu_rvalid_i) begin
                    bus.rvalid_o[owner_q] = 1'b1;
                    rr_ptr_d              = wrap_inc(owner_q);
                    state_d               = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.apu_operands_o = bus.operands_i[sel_idx];
    assign bus.apu_op_o       = bus.op_i[sel_idx];
    assign bus.apu_flags_o    = bus.flags_i[sel_idx];
    assign bus.rdata_o        = bus.apu_rdata_i;
    assign bus.rflags_o       = bus.apu_rflags_i;
    assign busy_o             = (state_q != IDLE);
    assign owner_o            = owner_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Protocol checks: a core must not withdraw a pending request, and the FPU
    // must not answer when nothing is in flight.
    a_owner_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == WAIT_GNT) |-> bus.req_i[owner_q]);
    a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == IDLE && bus.apu_rvalid_i) |-> (bus.apu_req_o && bus.apu_gnt_i));
    a_rvalid_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.rvalid_o));

endmodule
